mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter peripheral on the Hack CPU data bus, responding to CPU stores and loads in the I/O window above RAM. The CPU writes a byte to TXDATA. The block buffers it in a one-entry holding register, then serializes it 8N1, LSB first, on `o_tx`. A STATUS register gives the CPU busy, full and overrun flags; the SoC read mux selects `o_rdata` when `o_sel` is high.

---
 rtl/hack_mmio_pkg.sv | 24 ++
 rtl/uart_tx_core.sv | 87 ++++++++
 rtl/mmio_uart_tx.sv | 96 +++++++++
 tb/tb_mmio_uart_tx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_mmio_pkg.sv
// Hack SoC memory map, UART STATUS bit positions and UART transmitter state encoding.
package hack_mmio_pkg;

    localparam logic [14:0] MEM_RAM_BASE    = 15'h0000;
    localparam logic [14:0] MEM_SCREEN      = 15'h4000;
    localparam logic [14:0] MEM_KBD         = 15'h6000;
    localparam logic [14:0] MEM_SW          = 15'h6001;
    localparam logic [14:0] MEM_KEYS        = 15'h6002;
    localparam logic [14:0] MEM_LEDG        = 15'h6003;
    localparam logic [14:0] MEM_UART_TXDATA = 15'h6004;
    localparam logic [14:0] MEM_UART_STATUS = 15'h6005;

    localparam int ST_BUSY = 0;
    localparam int ST_FULL = 1;
    localparam int ST_OVR  = 2;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serializer, LSB first, with a valid/ready byte load. Ready also in the last
// stop-bit cycle so a waiting byte follows with no idle gap.
module uart_tx_core
    import hack_mmio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_clk_mem,
    input  logic       i_reset,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_active
);

    localparam int              CW     = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   RELOAD = CW'(CLKS_PER_BIT - 1);

    uart_state_t   state;
    logic [CW-1:0] baud;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          bit_done;
    logic          load;

    assign bit_done = (baud == '0);
    assign o_active = (state != UART_IDLE);
    assign o_ready  = (state == UART_IDLE) || ((state == UART_STOP) && bit_done);
    assign load     = i_valid && o_ready;

    // o_tx is registered alongside the state so the line value changes on the same edge.
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk_mem or posedge i_reset) begin
        if (i_reset) begin
            state <= UART_IDLE;
            baud  <= '0;
            idx   <= '0;
            shift <= '0;
            o_tx  <= 1'b1;
        end else if (load) begin
            state <= UART_START;
            baud  <= RELOAD;
            shift <= i_byte;
            o_tx  <= 1'b0;
        end else begin
            case (state)
                UART_IDLE: o_tx <= 1'b1;
                UART_START: begin
                    if (bit_done) begin
                        state <= UART_DATA;
                        idx   <= '0;
                        baud  <= RELOAD;
                        o_tx  <= shift[0];
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                UART_DATA: begin
                    if (bit_done) begin
                        baud <= RELOAD;
                        if (idx == 3'd7) begin
                            state <= UART_STOP;
                            o_tx  <= 1'b1;
                        end else begin
                            idx  <= idx + 3'd1;
                            o_tx <= shift[idx + 3'd1];
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                UART_STOP: begin
                    if (bit_done) begin
                        state <= UART_IDLE;
                        o_tx  <= 1'b1;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                default: state <= UART_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS decode, one-entry holding register,
// sticky overrun flag and combinational read mux in front of uart_tx_core.
module mmio_uart_tx
    import hack_mmio_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [14:0] BASE_ADDR    = MEM_UART_TXDATA
) (
    input  logic        i_clk_mem,
    input  logic        i_reset,
    input  logic [14:0] i_address,
    input  logic [15:0] i_wdata,
    input  logic        i_wstb,
    output logic [15:0] o_rdata,
    output logic        o_sel,
    output logic        o_tx,
    output logic        o_busy
);

    localparam logic [14:0] STATUS_ADDR = BASE_ADDR + 15'd1;

    logic       sel_data;
    logic       sel_status;
    logic       push;
    logic       clr_ovr;
    logic       drain;
    logic       slot_free;
    logic       hold_full;
    logic [7:0] hold_byte;
    logic       overrun;
    logic       core_ready;
    logic       core_active;
    logic       busy;
    logic       unused_wdata;

    assign sel_data   = (i_address == BASE_ADDR);
    assign sel_status = (i_address == STATUS_ADDR);
    assign push       = i_wstb && sel_data;
    assign clr_ovr    = i_wstb && sel_status && i_wdata[ST_OVR];
    // A slot being handed to the shifter this cycle can take a new byte on the same edge.
    assign drain      = hold_full && core_ready;
    assign slot_free  = !hold_full || drain;
    assign busy       = hold_full || core_active;
    assign o_busy     = busy;
    assign o_sel      = sel_data || sel_status;
    assign unused_wdata = ^i_wdata[15:8];

    always_ff @(posedge i_clk_mem or posedge i_reset) begin
        if (i_reset) begin
            hold_full <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (push && slot_free) begin
                hold_full <= 1'b1;
            end else if (drain) begin
                hold_full <= 1'b0;
            end
            if (push && !slot_free) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

    // NOTE: the holding byte has no reset; it is only consumed while hold_full is set,
    // and hold_full itself is reset.
    always_ff @(posedge i_clk_mem) begin
        if (push && slot_free) begin
            hold_byte <= i_wdata[7:0];
        end
    end

    // NOTE: o_rdata gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        o_rdata = '0;
        if (sel_status) begin
            o_rdata[ST_BUSY] = busy;
            o_rdata[ST_FULL] = hold_full;
            o_rdata[ST_OVR]  = overrun;
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .i_clk_mem(i_clk_mem),
        .i_reset  (i_reset),
        .i_valid  (hold_full),
        .i_byte   (hold_byte),
        .o_ready  (core_ready),
        .o_tx     (o_tx),
        .o_active (core_active)
    );

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: frame-timing reference model compared every
// cycle, directed scenarios pinned with literal expectations, then random traffic.
module tb_mmio_uart_tx;

    localparam int          C  = 4;
    localparam logic [14:0] TX = 15'h6004;
    localparam logic [14:0] ST = 15'h6005;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] address = ST;
    logic [15:0] wdata = '0;
    logic        wstb = 1'b0;
    logic [15:0] rdata;
    logic        sel;
    logic        tx;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    mmio_uart_tx #(
        .CLKS_PER_BIT(C),
        .BASE_ADDR   (TX)
    ) dut (
        .i_clk_mem(clk),
        .i_reset  (reset),
        .i_address(address),
        .i_wdata  (wdata),
        .i_wstb   (wstb),
        .o_rdata  (rdata),
        .o_sel    (sel),
        .o_tx     (tx),
        .o_busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is just a byte plus the edge it started on; the line
    // value is derived from elapsed time since that edge.
    int         m_cyc = 0;
    bit         f_act = 1'b0;
    int         f_start = 0;
    logic [7:0] f_byte = '0;
    bit         h_v = 1'b0;
    logic [7:0] h_b = '0;
    bit         m_ovr = 1'b0;
    bit         m_ready, m_drain, m_free, m_push, m_clr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cyc = 0;
            f_act = 1'b0;
            h_v   = 1'b0;
            m_ovr = 1'b0;
        end else begin
            m_cyc++;
            m_ready = !f_act || (m_cyc - f_start == 10 * C);
            m_drain = h_v && m_ready;
            m_free  = !h_v || m_drain;
            m_push  = wstb && (address == TX);
            m_clr   = wstb && (address == ST) && wdata[2];
            if (m_drain) begin
                f_act   = 1'b1;
                f_start = m_cyc;
                f_byte  = h_b;
            end else if (f_act && (m_cyc - f_start == 10 * C)) begin
                f_act = 1'b0;
            end
            if (m_push && m_free) begin
                h_v = 1'b1;
                h_b = wdata[7:0];
            end else if (m_drain) begin
                h_v = 1'b0;
            end
            if (m_push && !m_free) m_ovr = 1'b1;
            else if (m_clr)        m_ovr = 1'b0;
        end
    end

    function automatic logic exp_tx();
        int bitn;
        if (!f_act) return 1'b1;
        bitn = (m_cyc - f_start) / C;
        if (bitn == 0) return 1'b0;
        if (bitn <= 8) return f_byte[bitn-1];
        return 1'b1;
    endfunction

    function automatic logic [15:0] exp_rdata();
        if (address == ST) return {13'b0, m_ovr, h_v, h_v || f_act};
        return 16'h0000;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_tx",    {15'b0, tx},   {15'b0, exp_tx()});
            check("model_busy",  {15'b0, busy}, {15'b0, h_v || f_act});
            check("model_sel",   {15'b0, sel},  {15'b0, (address == TX) || (address == ST)});
            check("model_rdata", rdata,         exp_rdata());
        end
    end

    logic        rec_tx   [0:199];
    logic        rec_busy [0:199];
    logic [15:0] rec_rd   [0:199];

    // One bus cycle: inputs change just after a rising edge, return at the falling edge.
    task automatic cyc(input logic [14:0] a, input logic [15:0] d, input bit s);
        @(posedge clk);
        #2;
        address = a;
        wdata   = d;
        wstb    = s;
        @(negedge clk);
    endtask

    task automatic record(input int i);
        rec_tx[i]   = tx;
        rec_busy[i] = busy;
        rec_rd[i]   = rdata;
    endtask

    function automatic logic [7:0] decode(input int base);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = rec_tx[base + C * (b + 1) + C / 2];
        return r;
    endfunction

    function automatic int busy_count(input int n);
        int k = 0;
        for (int i = 0; i < n; i++) if (rec_busy[i]) k++;
        return k;
    endfunction

    logic [9:0] a5_seq;
    bit         line_ok;
    int         pick;

    initial begin
        a5_seq = 10'b11_0100_1010;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1'b1;

        cyc(ST, 16'h0, 1'b0);
        check("reset_tx", {15'b0, tx}, 16'h0001);
        check("reset_status", rdata, 16'h0000);

        // Single byte A5
        cyc(TX, 16'h00A5, 1'b1);
        for (int i = 0; i < 45; i++) begin
            cyc(ST, 16'h0, 1'b0);
            record(i);
        end
        check("a5_busy_after_push", {15'b0, rec_busy[0]}, 16'h0001);
        check("a5_tx_before_start", {15'b0, rec_tx[0]}, 16'h0001);
        for (int b = 0; b < 10; b++)
            check($sformatf("a5_bit%0d", b), {15'b0, rec_tx[1 + C * b + C / 2]}, {15'b0, a5_seq[b]});
        check("a5_busy_cycles", 16'(busy_count(45)), 16'd41);
        check("a5_status_after", rec_rd[44], 16'h0000);

        // Back-to-back 55 then 0F
        cyc(TX, 16'h0055, 1'b1);
        for (int i = 0; i < 90; i++) begin
            if (i == 15) cyc(TX, 16'h000F, 1'b1);
            else         cyc(ST, 16'h0, 1'b0);
            record(i);
        end
        check("b2b_status_mid", rec_rd[20], 16'h0003);
        check("b2b_status_late", rec_rd[38], 16'h0003);
        check("b2b_byte0", {8'b0, decode(1)}, 16'h0055);
        check("b2b_byte1", {8'b0, decode(41)}, 16'h000F);
        check("b2b_stop_last", {15'b0, rec_tx[40]}, 16'h0001);
        check("b2b_start_next", {15'b0, rec_tx[41]}, 16'h0000);
        check("b2b_busy_cycles", 16'(busy_count(90)), 16'd81);

        // Overrun: 01 sent, 02 held, 03 dropped
        cyc(TX, 16'h0001, 1'b1);
        for (int i = 0; i < 90; i++) begin
            if (i == 5)       cyc(TX, 16'h0002, 1'b1);
            else if (i == 10) cyc(TX, 16'h0003, 1'b1);
            else              cyc(ST, 16'h0, 1'b0);
            record(i);
        end
        check("ovr_status_set", rec_rd[12], 16'h0007);
        check("ovr_byte0", {8'b0, decode(1)}, 16'h0001);
        check("ovr_byte1", {8'b0, decode(41)}, 16'h0002);
        check("ovr_no_third", {15'b0, rec_busy[81]}, 16'h0000);
        check("ovr_status_idle", rec_rd[85], 16'h0004);
        cyc(ST, 16'h0004, 1'b1);
        cyc(ST, 16'h0000, 1'b0);
        check("ovr_cleared", rdata, 16'h0000);

        // Push in the idle drain cycle
        cyc(TX, 16'h003C, 1'b1);
        cyc(TX, 16'h00C3, 1'b1);
        for (int i = 0; i < 90; i++) begin
            cyc(ST, 16'h0, 1'b0);
            record(i);
        end
        check("drain_idle_status", rec_rd[2], 16'h0003);
        check("drain_idle_byte0", {8'b0, decode(0)}, 16'h003C);
        check("drain_idle_byte1", {8'b0, decode(40)}, 16'h00C3);
        check("drain_idle_done", {15'b0, rec_busy[80]}, 16'h0000);

        // Push in the last stop-bit cycle while hold is full
        cyc(TX, 16'h0081, 1'b1);
        for (int i = 0; i < 130; i++) begin
            if (i == 5)       cyc(TX, 16'h0042, 1'b1);
            else if (i == 40) cyc(TX, 16'h0099, 1'b1);
            else              cyc(ST, 16'h0, 1'b0);
            record(i);
        end
        check("drain_stop_status", rec_rd[45], 16'h0003);
        check("drain_stop_byte0", {8'b0, decode(1)}, 16'h0081);
        check("drain_stop_byte1", {8'b0, decode(41)}, 16'h0042);
        check("drain_stop_byte2", {8'b0, decode(81)}, 16'h0099);
        check("drain_stop_done", {15'b0, rec_busy[121]}, 16'h0000);

        // Reset mid-frame with a byte waiting in hold
        cyc(TX, 16'h00A5, 1'b1);
        cyc(TX, 16'h003C, 1'b1);
        cyc(ST, 16'h0, 1'b0);
        cyc(ST, 16'h0, 1'b0);
        check("rst_pre_tx", {15'b0, tx}, 16'h0000);
        #1 reset = 1'b1;
        #1;
        check("rst_now_tx", {15'b0, tx}, 16'h0001);
        check("rst_now_busy", {15'b0, busy}, 16'h0000);
        check("rst_now_status", rdata, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        line_ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cyc(ST, 16'h0, 1'b0);
            if (tx !== 1'b1 || busy !== 1'b0) line_ok = 1'b0;
        end
        check("rst_no_spurious", {15'b0, line_ok}, 16'h0001);

        // Decode
        cyc(ST, 16'h0, 1'b0);
        check("dec_status_sel", {15'b0, sel}, 16'h0001);
        check("dec_status_rd", rdata, 16'h0000);
        cyc(15'h6006, 16'h0, 1'b0);
        check("dec_6006_sel", {15'b0, sel}, 16'h0000);
        check("dec_6006_rd", rdata, 16'h0000);
        cyc(15'h6003, 16'h00FF, 1'b1);
        line_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(ST, 16'h0, 1'b0);
            if (tx !== 1'b1 || busy !== 1'b0) line_ok = 1'b0;
        end
        check("dec_6003_ignored", {15'b0, line_ok}, 16'h0001);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            pick = $urandom_range(0, 99);
            if (pick < 4) begin
                cyc(TX, 16'($urandom), 1'b1);
            end else if (pick < 7) begin
                cyc(ST, 16'($urandom), 1'b1);
            end else if (pick < 9) begin
                cyc(($urandom_range(0, 1) == 0) ? 15'h6003 : 15'($urandom), 16'($urandom), 1'b1);
            end else begin
                case ($urandom_range(0, 3))
                    0:       cyc(TX, 16'($urandom), 1'b0);
                    1:       cyc(ST, 16'($urandom), 1'b0);
                    2:       cyc(15'h6006, 16'($urandom), 1'b0);
                    default: cyc(15'($urandom), 16'($urandom), 1'b0);
                endcase
            end
            if (n == 1500) begin
                #1 reset = 1'b1;
                #2 reset = 1'b0;
            end
        end

        cyc(ST, 16'h0, 1'b0);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
